multiplexador_display: RTL and testbench
========================================

# multiplexador_display

Parametrised time-multiplexed driver for a common-anode/cathode multi-digit 7-segment display. It sits between the timekeeping counters and the board display pins. It scans DIGITOS BCD digits with a programmable per-digit slot length and snapshots each frame for coherent display. It adds leading-zero suppression, per-digit decimal points, per-digit blinking, an anti-ghosting dead cycle and an end-of-scan strobe.

## Interface
- DIGITOS, 4: number of digits scanned; legal range 1..8.
- PRESCALER, 50000: clock cycles per digit slot; must be ≥ 2.
- BLINK_DIV, 256: full scans per blink half-period; must be ≥ 1.
- ATIVO_BAIXO, 1: 1 means digit enables and segments are active-low; 0 means active-high.
- clock  in  1  system clock; all state updates on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- digitos  in  4*DIGITOS  BCD values; nibble i is digit i, and digit 0 is least significant.
- pontos  in  DIGITOS  decimal-point enable per digit.
- piscar  in  DIGITOS  blink mask per digit.
- supressaoZeros  in  1  enables leading-zero blanking.
- habilitar  in  1  0 blanks all digits; scanning continues.
- displayDigits  out  DIGITOS  digit enables; one-hot active, or none active.
- displaySegments  out  8  segment bits {dp,g,f,e,d,c,b,a}, with bit0 = a.
- fimVarredura  out  1  one-cycle pulse at the end of each full scan.

## Operation
- **Prescaler.** Counter p runs 0..PRESCALER-1 and wraps to 0.
- **Slot index.** Index s runs 0..DIGITOS-1. It advances when p = PRESCALER-1 and wraps to 0 after DIGITOS-1.
- **Scan counter.** Counter v runs 0..BLINK_DIV-1 and advances on every scan wrap (s = DIGITOS-1 and p = PRESCALER-1). When v wraps, blink phase f toggles.
- **Frame shadow.** The shadow registers take digitos, pontos, piscar and supressaoZeros in every cycle where s = 0 and p = 0, including the first cycle after reset release. All display decisions use the shadow values only; habilitar is the exception and acts live.
- **Decoding.**
  - 0..9 use standard patterns.
  - Any nibble 10..15 shows a dash (g only).
  - dp comes from the shadowed pontos[s].
- **Suppression.** This applies only when shadow supressaoZeros = 1.
  - Starting from digit DIGITOS-1 and moving down, each digit with value 0 is blanked until the first nonzero digit is reached.
  - Digit 0 is never suppressed.
  - A suppressed digit also suppresses its dp.
- **Digit enable.** Digit s is enabled only when all of these hold: p ≠ 0 (dead cycle), habilitar = 1, not suppressed, and not (shadow piscar[s] = 1 and f = 0).
- **Blanked slot.** When the digit is blanked, all digit enables and all segments are inactive.
- **Polarity.** ATIVO_BAIXO = 1 inverts both output buses. fimVarredura is always active-high.

## Timing
- **Reset values** (resetN low, asynchronous):
  - p = 0, s = 0, v = 0, f = 1 (visible), shadow = 0.
  - displayDigits: all inactive (all ones when ATIVO_BAIXO = 1).
  - displaySegments: all inactive (0xFF when ATIVO_BAIXO = 1).
  - fimVarredura = 0.
- **Output registers.** displayDigits, displaySegments and fimVarredura are registered. Each reflects the state (p, s, f, shadow, habilitar) of the previous cycle, a latency of one clock.
- **Slot length.** Each slot lasts PRESCALER cycles, of which the first is a dead cycle. The digit is therefore active for PRESCALER-1 cycles.
- **Scan length.** DIGITOS*PRESCALER cycles. fimVarredura is high for exactly one cycle per scan, in the cycle after s = DIGITOS-1 and p = PRESCALER-1.
- **Blink.** Half-period is BLINK_DIV scans, i.e. BLINK_DIV*DIGITOS*PRESCALER cycles.
- **Input changes mid-scan.** Changes to digitos, pontos, piscar or supressaoZeros are not visible until the next slot 0 in which p = 0, plus one clock.
- **habilitar.** Takes effect one clock after it changes.
- **Reset mid-scan.** Outputs go inactive immediately. Scanning restarts at slot 0 with a dead cycle.
- **DIGITOS = 1.** Every slot wrap is also a scan wrap.

## Structure
- **Shared package** `display_pkg` holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_TRACO;
  - the segment bit-order constants;
  - a constant for the maximum DIGITOS (8).
- **Sub-module** `decodificador_sete_segmentos` is combinational: 4-bit BCD in, 7-bit active-high pattern out, with a dash for values above 9.
- **Top level** contains the prescaler, slot and scan counters, the blink phase, the shadow registers, suppression logic, polarity inversion and the output registers.

## Test plan
All scenarios use DIGITOS=4, PRESCALER=4, BLINK_DIV=2, ATIVO_BAIXO=1.
- **Reset:** hold resetN low → displayDigits = 4'b1111, displaySegments = 8'hFF, fimVarredura = 0. After release, cycle 1 is dead (all 1s) and digit 0 becomes active (4'b1110) from cycle 2.
- **Basic scan:** digitos = 16'h1234, others 0, habilitar = 1.
  - Slot 0 shows segments 8'h99 ("4").
  - Slot 3 shows 8'hF9 ("1").
  - Each slot has one dead cycle followed by 3 active cycles.
  - fimVarredura pulses every 16 cycles.
- **Leading-zero suppression:**
  - digitos = 16'h0070, supressaoZeros = 1 → digits 3 and 2 are never enabled, digit 1 shows 8'hF8 ("7"), digit 0 shows 8'hC0 ("0").
  - digitos = 16'h0000 → only digit 0 is enabled.
- **Blink and dp:** piscar = 4'b0001, pontos = 4'b0001.
  - Digit 0 is enabled with segments 8'h40 ("0" plus dp) for 2 scans (32 cycles).
  - It is then disabled for 32 cycles while digits 1..3 stay unaffected.
- **Frame coherence and dash:** change digitos from 16'h1234 to 16'h123A during slot 2.
  - Slot 3 still shows "1".
  - In the next scan, slot 0 shows a dash (8'hBF).
  - Deasserting habilitar makes all digits inactive within 1 clock.
- **Async reset mid-scan:** pulse resetN low during slot 2 → outputs inactive with no clock edge, and the scan restarts at slot 0.

Source files
------------

// File: rtl/multiplexador_display_pkg.sv
// Shared constants for the multiplexed 7-segment driver: segment patterns,
// segment bit positions and the BCD-to-pattern helper.
package display_pkg;

    localparam int MAX_DIGITOS = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef logic [6:0] padrao_t;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam padrao_t SEG_0     = 7'h3F;
    localparam padrao_t SEG_1     = 7'h06;
    localparam padrao_t SEG_2     = 7'h5B;
    localparam padrao_t SEG_3     = 7'h4F;
    localparam padrao_t SEG_4     = 7'h66;
    localparam padrao_t SEG_5     = 7'h6D;
    localparam padrao_t SEG_6     = 7'h7D;
    localparam padrao_t SEG_7     = 7'h07;
    localparam padrao_t SEG_8     = 7'h7F;
    localparam padrao_t SEG_9     = 7'h6F;
    localparam padrao_t SEG_TRACO = 7'h40;

    function automatic padrao_t padraoBcd(input logic [3:0] valor);
        case (valor)
            4'd0:    padraoBcd = SEG_0;
            4'd1:    padraoBcd = SEG_1;
            4'd2:    padraoBcd = SEG_2;
            4'd3:    padraoBcd = SEG_3;
            4'd4:    padraoBcd = SEG_4;
            4'd5:    padraoBcd = SEG_5;
            4'd6:    padraoBcd = SEG_6;
            4'd7:    padraoBcd = SEG_7;
            4'd8:    padraoBcd = SEG_8;
            4'd9:    padraoBcd = SEG_9;
            default: padraoBcd = SEG_TRACO;
        endcase
    endfunction

endpackage

// File: rtl/multiplexador_display_if.sv
// Bundle of the BCD/control inputs and the display pin outputs of the
// multiplexed display driver.
interface multiplexador_display_if #(
    parameter int DIGITOS = 4
);
    logic [4*DIGITOS-1:0] digitos;
    logic [DIGITOS-1:0]   pontos;
    logic [DIGITOS-1:0]   piscar;
    logic                 supressaoZeros;
    logic                 habilitar;
    logic [DIGITOS-1:0]   displayDigits;
    logic [7:0]           displaySegments;
    logic                 fimVarredura;

    modport master (
        output digitos, pontos, piscar, supressaoZeros, habilitar,
        input  displayDigits, displaySegments, fimVarredura
    );

    modport slave (
        input  digitos, pontos, piscar, supressaoZeros, habilitar,
        output displayDigits, displaySegments, fimVarredura
    );
endinterface

// File: rtl/multiplexador_display_decodificador.sv
// Combinational BCD to 7-segment decoder; values above 9 show a dash.
module decodificador_sete_segmentos
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output padrao_t    segmentos
);

    always_comb begin
        segmentos = padraoBcd(bcd);
    end

endmodule

// File: rtl/multiplexador_display.sv
// Time-multiplexed multi-digit 7-segment driver with frame shadowing,
// leading-zero suppression, per-digit blink and a dead cycle per slot.
module multiplexador_display
    import display_pkg::*;
#(
    parameter int DIGITOS     = 4,
    parameter int PRESCALER   = 50000,
    parameter int BLINK_DIV   = 256,
    parameter int ATIVO_BAIXO = 1
) (
    input logic               clock,
    input logic               resetN,
    multiplexador_display_if.slave bus
);

    localparam int P_W = $clog2(PRESCALER);
    localparam int S_W = (DIGITOS > 1) ? $clog2(DIGITOS) : 1;
    localparam int V_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [P_W-1:0] P_MAX   = P_W'(PRESCALER - 1);
    localparam logic [S_W-1:0] S_MAX   = S_W'(DIGITOS - 1);
    localparam logic [V_W-1:0] V_MAX   = V_W'(BLINK_DIV - 1);
    localparam logic           INVERTE = (ATIVO_BAIXO != 0);

    logic [P_W-1:0]       prescala;
    logic [S_W-1:0]       slot;
    logic [V_W-1:0]       varreduras;
    logic                 fase;

    logic [4*DIGITOS-1:0] sombraDigitos;
    logic [DIGITOS-1:0]   sombraPontos;
    logic [DIGITOS-1:0]   sombraPiscar;
    logic                 sombraSupressao;

    logic                 fimSlot;
    logic                 fimScan;
    logic                 inicioQuadro;

    logic [DIGITOS-1:0]   mascaraSupressao;
    logic                 zerosAcima;
    logic [3:0]           nibbleAtual;
    logic                 pontoAtual;
    logic                 piscarAtual;
    logic                 suprimidoAtual;
    logic                 habilitado;
    logic [DIGITOS-1:0]   digitosAtivos;
    logic [7:0]           segmentosAtivos;
    padrao_t              padrao;

    assign fimSlot      = (prescala == P_MAX);
    assign fimScan      = fimSlot && (slot == S_MAX);
    assign inicioQuadro = (prescala == '0) && (slot == '0);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            prescala   <= '0;
            slot       <= '0;
            varreduras <= '0;
            fase       <= 1'b1;
        end else begin
            prescala <= fimSlot ? '0 : prescala + 1'b1;
            if (fimSlot) begin
                slot <= (slot == S_MAX) ? '0 : slot + 1'b1;
            end
            // Blink phase flips once every BLINK_DIV complete scans
            if (fimScan) begin
                if (varreduras == V_MAX) begin
                    varreduras <= '0;
                    fase       <= ~fase;
                end else begin
                    varreduras <= varreduras + 1'b1;
                end
            end
        end
    end

    // Snapshot the frame at the start of slot 0 so a scan never mixes two values
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sombraDigitos   <= '0;
            sombraPontos    <= '0;
            sombraPiscar    <= '0;
            sombraSupressao <= 1'b0;
        end else if (inicioQuadro) begin
            sombraDigitos   <= bus.digitos;
            sombraPontos    <= bus.pontos;
            sombraPiscar    <= bus.piscar;
            sombraSupressao <= bus.supressaoZeros;
        end
    end

    // Walk from the most significant digit down; digit 0 always stays visible
    always_comb begin
        zerosAcima       = 1'b1;
        mascaraSupressao = '0;
        for (int i = DIGITOS - 1; i >= 0; i--) begin
            zerosAcima = zerosAcima && (sombraDigitos[4*i +: 4] == 4'd0);
            if (i != 0) begin
                mascaraSupressao[i] = sombraSupressao && zerosAcima;
            end
        end
    end

    always_comb begin
        nibbleAtual    = '0;
        pontoAtual     = 1'b0;
        piscarAtual    = 1'b0;
        suprimidoAtual = 1'b0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (S_W'(i) == slot) begin
                nibbleAtual    = sombraDigitos[4*i +: 4];
                pontoAtual     = sombraPontos[i];
                piscarAtual    = sombraPiscar[i];
                suprimidoAtual = mascaraSupressao[i];
            end
        end
    end

    decodificador_sete_segmentos decodificador (
        .bcd       (nibbleAtual),
        .segmentos (padrao)
    );

    always_comb begin
        habilitado = (prescala != '0) && bus.habilitar && !suprimidoAtual
                     && !(piscarAtual && !fase);
        digitosAtivos   = '0;
        segmentosAtivos = '0;
        for (int i = 0; i < DIGITOS; i++) begin
            if (S_W'(i) == slot) begin
                digitosAtivos[i] = habilitado;
            end
        end
        if (habilitado) begin
            segmentosAtivos[SEG_G:SEG_A] = padrao;
            segmentosAtivos[SEG_DP]      = pontoAtual;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            bus.displayDigits   <= {DIGITOS{INVERTE}};
            bus.displaySegments <= {8{INVERTE}};
            bus.fimVarredura    <= 1'b0;
        end else begin
            bus.displayDigits   <= digitosAtivos ^ {DIGITOS{INVERTE}};
            bus.displaySegments <= segmentosAtivos ^ {8{INVERTE}};
            bus.fimVarredura    <= fimScan;
        end
    end

endmodule

// File: tb/tb_multiplexador_display.sv
// Scoreboard bench for multiplexador_display with DIGITOS=4, PRESCALER=4,
// BLINK_DIV=2, active-low outputs; expectations are hand-derived per slot.
module tb_multiplexador_display;

    typedef struct {
        int         cyc;
        logic [3:0] dig;
        logic [7:0] seg;
        logic       fim;
        string      nome;
    } esperado_t;

    logic clock;
    logic resetN;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    int   c0;

    esperado_t fila[$];
    esperado_t atual;

    multiplexador_display_if #(.DIGITOS(4)) bus ();

    multiplexador_display #(
        .DIGITOS     (4),
        .PRESCALER   (4),
        .BLINK_DIV   (2),
        .ATIVO_BAIXO (1)
    ) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string nome, input int ciclo, input logic [3:0] eDig,
                               input logic [7:0] eSeg, input logic eFim);
        checks++;
        if ({bus.displayDigits, bus.displaySegments, bus.fimVarredura} !== {eDig, eSeg, eFim}) begin
            errors++;
            $display("[TB] FAIL %s cyc=%0d: got dig=%b seg=%h fim=%b, expected dig=%b seg=%h fim=%b",
                     nome, ciclo, bus.displayDigits, bus.displaySegments, bus.fimVarredura,
                     eDig, eSeg, eFim);
        end
    endtask

    // Monitor: compares every queued expectation whose cycle has come up
    always @(negedge clock) begin
        while (fila.size() > 0 && fila[0].cyc <= cyc) begin
            atual = fila.pop_front();
            if (atual.cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cyc=%0d missed at cyc=%0d", atual.nome, atual.cyc, cyc);
            end else begin
                checkOutput(atual.nome, cyc, atual.dig, atual.seg, atual.fim);
            end
        end
    end

    // k counts clocks after reset release; output at k reflects state (p,s) before edge k
    task automatic pushScan(input string nome, input int base, input int kIni, input int kFim,
                            input logic [31:0] segs, input logic [3:0] mask);
        for (int k = kIni; k <= kFim; k++) begin
            int p;
            int s;
            esperado_t e;
            p = (k - 1) % 4;
            s = ((k - 1) / 4) % 4;
            e.cyc  = base + k;
            e.nome = $sformatf("%s k%0d", nome, k);
            e.fim  = (((k - 1) % 16) == 15);
            if (p == 0 || !mask[s]) begin
                e.dig = 4'hF;
                e.seg = 8'hFF;
            end else begin
                e.dig = ~(4'b0001 << s);
                e.seg = segs[8*s +: 8];
            end
            fila.push_back(e);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] pt, input logic [3:0] pi,
                                 input logic sup, input logic hab, output int base);
        @(negedge clock);
        resetN             = 1'b0;
        bus.digitos        = d;
        bus.pontos         = pt;
        bus.piscar         = pi;
        bus.supressaoZeros = sup;
        bus.habilitar      = hab;
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        base   = cyc;
    endtask

    task automatic waitDrain(input int limite);
        int n;
        n = 0;
        while (fila.size() > 0 && n < limite) begin
            @(negedge clock);
            n++;
        end
        if (fila.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: %0d expectations pending, required 0", fila.size());
            fila.delete();
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    localparam logic [31:0] SEGS_1234 = {8'hF9, 8'hA4, 8'hB0, 8'h99};
    localparam logic [31:0] SEGS_123A = {8'hF9, 8'hA4, 8'hB0, 8'hBF};

    initial begin
        resetN             = 1'b0;
        bus.digitos        = '0;
        bus.pontos         = '0;
        bus.piscar         = '0;
        bus.supressaoZeros = 1'b0;
        bus.habilitar      = 1'b1;

        repeat (3) @(negedge clock);
        checkOutput("resetHeld", cyc, 4'hF, 8'hFF, 1'b0);

        applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, c0);
        pushScan("basic", c0, 1, 48, SEGS_1234, 4'hF);
        waitDrain(60);

        applyStimulus(16'h0070, 4'b0000, 4'b0000, 1'b1, 1'b1, c0);
        pushScan("supp0070", c0, 1, 32, {8'hFF, 8'hFF, 8'hF8, 8'hC0}, 4'b0011);
        waitDrain(40);

        applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1, c0);
        pushScan("supp0000", c0, 1, 20, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, 4'b0001);
        waitDrain(30);

        applyStimulus(16'h0000, 4'b0001, 4'b0001, 1'b0, 1'b1, c0);
        pushScan("blinkOn", c0, 1, 32, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1111);
        pushScan("blinkOff", c0, 33, 64, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1110);
        pushScan("blinkBack", c0, 65, 72, {8'hC0, 8'hC0, 8'hC0, 8'h40}, 4'b1111);
        waitDrain(80);

        applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, c0);
        pushScan("frameOld", c0, 1, 16, SEGS_1234, 4'hF);
        pushScan("frameDash", c0, 17, 34, SEGS_123A, 4'hF);
        pushScan("habOff", c0, 35, 40, SEGS_123A, 4'h0);
        while (cyc < c0 + 10) @(negedge clock);
        bus.digitos = 16'h123A;
        while (cyc < c0 + 34) @(negedge clock);
        bus.habilitar = 1'b0;
        waitDrain(40);
        bus.habilitar = 1'b1;

        applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b1, c0);
        pushScan("preReset", c0, 1, 11, SEGS_1234, 4'hF);
        while (cyc < c0 + 11) @(negedge clock);
        #2 resetN = 1'b0;
        #1 checkOutput("asyncReset", cyc, 4'hF, 8'hFF, 1'b0);
        @(negedge clock);
        checkOutput("asyncResetHeld", cyc, 4'hF, 8'hFF, 1'b0);
        resetN = 1'b1;
        c0     = cyc;
        pushScan("restart", c0, 1, 8, SEGS_1234, 4'hF);
        waitDrain(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
